// File: rtl/nonce_hub.sv
// Round-robin collector of found-nonce tickets from SLAVES hashing cores, queued for the serial transmitter.
// Optional NONCE_HUB_CHANNEL_TAG_EN adds golden_channel, the source channel stored with each queued nonce.
module nonce_hub #(
    parameter int SLAVES      = 4,
    parameter int NONCE_WIDTH = 32,
    parameter int FIFO_DEPTH  = 8,
    parameter int ACK_TIMEOUT = 15,
    localparam int CH_W       = (SLAVES > 1) ? $clog2(SLAVES) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [SLAVES-1:0]               got_ticket,
    input  logic [SLAVES*NONCE_WIDTH-1:0]   slave_nonces,
    input  logic                            serial_busy,
    output logic                            serial_send,
    output logic [NONCE_WIDTH-1:0]          golden_nonce,
`ifdef NONCE_HUB_CHANNEL_TAG_EN
    output logic [CH_W-1:0]                 golden_channel,
`endif
    output logic                            new_nonce,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_count,
    output logic                            overflow,
    output logic [15:0]                     dropped_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT + 1) : 1;
    localparam int DW = $clog2(SLAVES + 1);
`ifdef NONCE_HUB_CHANNEL_TAG_EN
    localparam int EW = NONCE_WIDTH + CH_W;
`else
    localparam int EW = NONCE_WIDTH;
`endif

    typedef enum logic [1:0] {IDLE, SEND, ACK, DONE} state_t;
    state_t state, state_nx;

    logic [SLAVES-1:0]      ticket_q, edge_det, pend, clr, drop;
    logic [NONCE_WIDTH-1:0] hold [SLAVES];
    logic [CH_W-1:0]        ptr, grant;
    logic                   any_pend, push, pop, full, empty;
    logic [EW-1:0]          mem [FIFO_DEPTH];
    logic [EW-1:0]          entry;
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [TW-1:0]          ack_cnt;
    logic [DW-1:0]          drop_n;
    logic [16:0]            drop_sum;

    // Lowest pending channel at or above ptr, wrapping; smallest offset wins.
    always_comb begin
        int idx;
        any_pend = 1'b0;
        grant    = '0;
        idx      = 0;
        for (int k = SLAVES - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= SLAVES) idx = idx - SLAVES;
            if (pend[idx]) begin
                any_pend = 1'b1;
                grant    = CH_W'(idx);
            end
        end
    end

    assign empty    = (fifo_count == '0);
    assign full     = (fifo_count == (AW+1)'(FIFO_DEPTH));
    assign pop      = (state == IDLE) && !empty;
    assign push     = any_pend && (!full || pop);
    assign edge_det = got_ticket & ~ticket_q;
    assign drop     = edge_det & pend & ~clr;
    assign drop_sum = {1'b0, dropped_count} + 17'(drop_n);
`ifdef NONCE_HUB_CHANNEL_TAG_EN
    assign entry    = {grant, hold[grant]};
`else
    assign entry    = hold[grant];
`endif

    always_comb begin
        clr    = '0;
        drop_n = '0;
        if (push) clr[grant] = 1'b1;
        for (int i = 0; i < SLAVES; i++) drop_n = drop_n + DW'(drop[i]);
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < SLAVES; i++)
            if (edge_det[i] && !drop[i]) hold[i] <= slave_nonces[i*NONCE_WIDTH +: NONCE_WIDTH];
        if (push) mem[wr_ptr] <= entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ticket_q      <= '0;
            pend          <= '0;
            ptr           <= '0;
            new_nonce     <= 1'b0;
            overflow      <= 1'b0;
            dropped_count <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fifo_count    <= '0;
            golden_nonce  <= '0;
`ifdef NONCE_HUB_CHANNEL_TAG_EN
            golden_channel <= '0;
`endif
        end else begin
            ticket_q      <= got_ticket;
            // A fresh edge re-arms a channel even when its old ticket is granted this cycle.
            pend          <= (pend & ~clr) | edge_det;
            new_nonce     <= push;
            overflow      <= overflow | (|drop);
            dropped_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            if (push) begin
                ptr    <= (grant == CH_W'(SLAVES - 1)) ? '0 : grant + 1'b1;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr       <= rd_ptr + 1'b1;
                golden_nonce <= mem[rd_ptr][NONCE_WIDTH-1:0];
`ifdef NONCE_HUB_CHANNEL_TAG_EN
                golden_channel <= mem[rd_ptr][EW-1 -: CH_W];
`endif
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Handshake: serial_send is a one-cycle request with golden_nonce valid; the UART
    // acknowledges by raising serial_busy and completes by dropping it. A missing ack
    // after ACK_TIMEOUT cycles is treated as completion.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            ack_cnt <= '0;
        end else begin
            state   <= state_nx;
            ack_cnt <= (state == ACK) ? ack_cnt + 1'b1 : '0;
        end
    end

    always_comb begin
        state_nx    = state;
        serial_send = 1'b0;
        unique case (state)
            IDLE: if (!empty) state_nx = SEND;
            SEND: begin
                serial_send = 1'b1;
                state_nx    = ACK;
            end
            ACK: begin
                if (serial_busy) state_nx = DONE;
                else if (ack_cnt == TW'(ACK_TIMEOUT - 1)) state_nx = IDLE;
            end
            DONE: if (!serial_busy) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

endmodule

// File: tb/tb_nonce_hub.sv
// Directed bench for nonce_hub: queue-based reference model checked every cycle, plus literal expectations.
// Connects golden_channel when NONCE_HUB_CHANNEL_TAG_EN is defined.
module tb_nonce_hub;
    localparam int S  = 4;
    localparam int NW = 32;
    localparam int D  = 8;
    localparam int TO = 15;
    localparam int CW = 2;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [S-1:0]    got_ticket = '0;
    logic [S*NW-1:0] slave_nonces = '0;
    logic            serial_busy = 1'b0;
    logic            serial_send, new_nonce, overflow;
    logic [NW-1:0]   golden_nonce;
    logic [3:0]      fifo_count;
    logic [15:0]     dropped_count;
`ifdef NONCE_HUB_CHANNEL_TAG_EN
    logic [CW-1:0]   golden_channel;
`endif

    nonce_hub #(.SLAVES(S), .NONCE_WIDTH(NW), .FIFO_DEPTH(D), .ACK_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .got_ticket(got_ticket), .slave_nonces(slave_nonces),
        .serial_busy(serial_busy), .serial_send(serial_send), .golden_nonce(golden_nonce),
`ifdef NONCE_HUB_CHANNEL_TAG_EN
        .golden_channel(golden_channel),
`endif
        .new_nonce(new_nonce), .fifo_count(fifo_count), .overflow(overflow),
        .dropped_count(dropped_count)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    logic [NW-1:0] m_hold [S];
    logic [S-1:0]  m_pend, m_prev;
    logic [NW-1:0] m_fifo_n[$];
    int            m_fifo_c[$];
    int            m_ptr, m_phase, m_ack, m_drops, m_gch, m_g;
    logic [NW-1:0] m_gold;
    bit            m_new, m_ovf, m_valid, m_pop, m_push;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            m_pend = '0; m_prev = '0; m_ptr = 0; m_phase = 0; m_ack = 0;
            m_drops = 0; m_gch = 0; m_gold = '0; m_new = 0; m_ovf = 0;
            m_fifo_n.delete(); m_fifo_c.delete();
            m_valid = 1;
        end else begin
            m_pop = (m_phase == 0) && (m_fifo_n.size() > 0);
            m_g = -1;
            for (int k = 0; k < S; k++)
                if (m_g < 0 && m_pend[(m_ptr + k) % S]) m_g = (m_ptr + k) % S;
            m_push = (m_g >= 0) && (m_fifo_n.size() < D || m_pop);
            if (m_pop) begin
                m_gold = m_fifo_n.pop_front();
                m_gch  = m_fifo_c.pop_front();
            end
            if (m_push) begin
                m_fifo_n.push_back(m_hold[m_g]);
                m_fifo_c.push_back(m_g);
                m_pend[m_g] = 1'b0;
                m_ptr = (m_g + 1) % S;
            end
            m_new = m_push;
            for (int i = 0; i < S; i++) begin
                if (got_ticket[i] && !m_prev[i]) begin
                    if (m_pend[i]) begin
                        m_ovf = 1;
                        if (m_drops < 65535) m_drops++;
                    end else begin
                        m_hold[i] = slave_nonces[i*NW +: NW];
                        m_pend[i] = 1'b1;
                    end
                end
            end
            m_prev = got_ticket;
            case (m_phase)
                0: if (m_pop) m_phase = 1;
                1: begin m_phase = 2; m_ack = 0; end
                2: if (serial_busy) m_phase = 3;
                   else begin
                       m_ack++;
                       if (m_ack == TO) m_phase = 0;
                   end
                default: if (!serial_busy) m_phase = 0;
            endcase
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            check("serial_send", serial_send, m_phase == 1);
            check("new_nonce", new_nonce, m_new);
            check("fifo_count", fifo_count, m_fifo_n.size());
            check("overflow", overflow, m_ovf);
            check("dropped_count", dropped_count, m_drops);
            if (m_phase != 0) check("golden_nonce", golden_nonce, m_gold);
`ifdef NONCE_HUB_CHANNEL_TAG_EN
            if (m_phase != 0) check("golden_channel", golden_channel, m_gch);
`endif
        end
    end

    // ---------------- UART responder ----------------
    // mode 0: never busy; mode 1: busy 2 cycles after a send, for 10 cycles; mode 2: busy held
    int busy_mode = 0;
    int dly = 0;
    int busy_left = 0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (busy_mode == 2) serial_busy = 1'b1;
            else if (busy_mode == 0) serial_busy = 1'b0;
            else begin
                if (dly > 0) begin
                    dly--;
                    if (dly == 0) busy_left = 10;
                end
                if (busy_left > 0) begin
                    serial_busy = 1'b1;
                    busy_left--;
                end else serial_busy = 1'b0;
                if (serial_send) dly = 2;
            end
        end
    end

    // ---------------- driver tasks / scoreboard ----------------
    logic [NW-1:0] exp_q[$];
    logic [NW-1:0] sent_q[$];
    int            new_cyc_q[$];
    int            send_cyc_q[$];
    int            drive_cyc;

    task automatic watch(input int n);
        repeat (n) begin
            @(negedge clk);
            if (new_nonce === 1'b1) new_cyc_q.push_back(cyc);
            if (serial_send === 1'b1) begin
                sent_q.push_back(golden_nonce);
                send_cyc_q.push_back(cyc);
            end
        end
    endtask

    task automatic set_ticket(input int ch, input logic v, input logic [NW-1:0] n);
        slave_nonces[ch*NW +: NW] = n;
        got_ticket[ch] = v;
    endtask

    task automatic do_reset(input int mode);
        got_ticket = '0;
        busy_mode  = mode;
        rst = 1'b1;
        watch(2);
        rst = 1'b0;
        sent_q.delete(); new_cyc_q.delete(); send_cyc_q.delete(); exp_q.delete();
        drive_cyc = cyc;
    endtask

    task automatic check_sent(input string name);
        check({name, "_count"}, sent_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++)
            check(name, sent_q[i], exp_q[i]);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        do_reset(1);
        check("reset_fifo_count", fifo_count, 0);
        check("reset_serial_send", serial_send, 0);
        check("reset_dropped", dropped_count, 0);

        // single nonce on ch2
        set_ticket(2, 1'b1, 32'hDEADBEEF);
        drive_cyc = cyc;
        watch(30);
        got_ticket = '0;
        watch(2);
        exp_q = '{32'hDEADBEEF};
        check_sent("single_sent");
        check("single_new_pulses", new_cyc_q.size(), 1);
        check("single_push_latency", new_cyc_q[0] - drive_cyc, 2);
        check("single_send_latency", send_cyc_q[0] - drive_cyc, 3);
        check("single_fifo_empty", fifo_count, 0);

        // four simultaneous tickets, pointer at 0
        do_reset(1);
        for (int i = 0; i < S; i++) set_ticket(i, 1'b1, NW'(32'h10 + i));
        watch(80);
        got_ticket = '0;
        exp_q = '{32'h10, 32'h11, 32'h12, 32'h13};
        check_sent("simul_sent");
        check("simul_new_pulses", new_cyc_q.size(), 4);
        check("simul_consecutive", new_cyc_q[3] - new_cyc_q[0], 3);

        // round-robin: ch1 granted, then ch0 and ch3 together -> ch3 first
        do_reset(1);
        set_ticket(1, 1'b1, 32'h111);
        watch(4);
        set_ticket(0, 1'b1, 32'hA0);
        set_ticket(3, 1'b1, 32'hA3);
        watch(60);
        got_ticket = '0;
        exp_q = '{32'h111, 32'hA3, 32'hA0};
        check_sent("rr_sent");

        // pending collision with a full FIFO
        do_reset(2);
        for (int i = 0; i < S; i++) set_ticket(i, 1'b1, NW'(32'h200 + i));
        watch(1); got_ticket = '0; watch(6);
        for (int i = 0; i < S; i++) set_ticket(i, 1'b1, NW'(32'h210 + i));
        watch(1); got_ticket = '0; watch(6);
        set_ticket(2, 1'b1, 32'h222);
        watch(1); got_ticket = '0; watch(4);
        check("coll_fifo_full", fifo_count, 8);
        set_ticket(0, 1'b1, 32'h2A0);
        watch(1); got_ticket = '0; watch(1);
        set_ticket(0, 1'b1, 32'h2A1);
        watch(3);
        check("coll_dropped", dropped_count, 1);
        check("coll_overflow", overflow, 1);
        check("coll_fifo_still_full", fifo_count, 8);
        got_ticket = '0;
        busy_mode = 1;
        watch(160);
        exp_q = '{32'h200, 32'h201, 32'h202, 32'h203, 32'h210, 32'h211, 32'h212, 32'h213,
                  32'h222, 32'h2A0};
        check_sent("coll_sent");
        check("coll_fifo_drained", fifo_count, 0);
        check("coll_dropped_kept", dropped_count, 1);

        // ack timeout with busy tied low
        do_reset(0);
        set_ticket(0, 1'b1, 32'h501);
        set_ticket(1, 1'b1, 32'h502);
        watch(50);
        got_ticket = '0;
        exp_q = '{32'h501, 32'h502};
        check_sent("timeout_sent");
        check("timeout_spacing", send_cyc_q[1] - send_cyc_q[0], 17);

        // reset while in DONE with three queued and one drop recorded
        do_reset(2);
        for (int i = 0; i < S; i++) set_ticket(i, 1'b1, NW'(32'h600 + i));
        watch(1);
        got_ticket[3] = 1'b0;
        watch(1);
        set_ticket(3, 1'b1, 32'h6F3);
        watch(8);
        got_ticket = '0;
        watch(2);
        check("midrst_fifo_before", fifo_count, 3);
        check("midrst_dropped_before", dropped_count, 1);
        check("midrst_overflow_before", overflow, 1);
        rst = 1'b1;
        watch(1);
        check("midrst_fifo", fifo_count, 0);
        check("midrst_send", serial_send, 0);
        check("midrst_overflow", overflow, 0);
        check("midrst_dropped", dropped_count, 0);
        rst = 1'b0;
        busy_mode = 0;
        sent_q.delete();
        watch(20);
        check("midrst_no_resend", sent_q.size(), 0);

        #2;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
